// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t : fetch FSM state (FETCH issues reads, HALTED is terminal)
//   word_t        : 32-bit machine word
//   RESET_PC_DEF  : default PC loaded on reset
package pc_fetch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam word_t RESET_PC_DEF = 32'h0000_0000;

  // Instruction addresses are word aligned; drop the byte-offset bits.
  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(32'h3);
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch front end and PC owner for the pipelined MIPS datapath.
// Ports:
//   CLK, nRST          clock (rising edge) and asynchronous active-low reset
//   ihit, iload        memory handshake: iload is valid when ihit is high
//   stall              hazard unit asks IF/ID to hold
//   redirect, next_PC  one-cycle redirect pulse and its target
//   halt               halt committed; fetch stops until reset
//   imemREN, imemaddr  instruction read request
//   PC, PC4            current fetch PC and PC + 4
//   instr, instr_pc4,
//   instr_valid        IF/ID payload (instr_valid = 0 is a bubble)
//   fetch_count        saturating count of delivered instructions
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter word_t       RESET_PC = RESET_PC_DEF,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic [31:0]        iload,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        next_PC,
  input  logic               halt,
  output logic               imemREN,
  output logic [31:0]        imemaddr,
  output logic [31:0]        PC,
  output logic [31:0]        PC4,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc4,
  output logic               instr_valid,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_t       r_state;
  word_t              r_pc;
  word_t              r_instr;
  word_t              r_instr_pc4;
  logic               r_valid;
  logic [COUNT_W-1:0] r_count;
  logic               r_pend;
  word_t              r_pend_pc;

  word_t w_pc4;
  word_t w_target;
  logic  w_squash;
  logic  w_accept;

  assign w_pc4    = r_pc + 32'd4;
  assign w_target = word_align(next_PC);
  // A word arriving while a redirect is live (now or pending) is from the
  // wrong path: it is dropped even if the hazard unit is stalling.
  assign w_squash = ihit & (redirect | r_pend);
  assign w_accept = ihit & ~stall & ~redirect & ~r_pend;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_instr_pc4 <= '0;
      r_valid     <= 1'b0;
      r_count     <= '0;
      r_pend      <= 1'b0;
      r_pend_pc   <= '0;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (halt) begin
            r_state <= HALTED;
            r_valid <= 1'b0;
            r_pend  <= 1'b0;
          end else if (w_squash) begin
            r_pc    <= redirect ? w_target : r_pend_pc;
            r_valid <= 1'b0;
            r_pend  <= 1'b0;
          end else if (w_accept) begin
            r_pc        <= w_pc4;
            r_instr     <= iload;
            r_instr_pc4 <= w_pc4;
            r_valid     <= 1'b1;
            if (!(&r_count)) r_count <= r_count + 1'b1;
          end else begin
            // Redirect during a memory wait: remember it, newest wins.
            if (redirect) begin
              r_pend    <= 1'b1;
              r_pend_pc <= w_target;
            end
            if (!stall) r_valid <= 1'b0;
          end
        end
        HALTED: ;
        default: r_state <= HALTED;
      endcase
    end
  end

  assign imemREN     = (r_state == FETCH);
  assign imemaddr    = r_pc;
  assign PC          = r_pc;
  assign PC4         = w_pc4;
  assign instr       = r_instr;
  assign instr_pc4   = r_instr_pc4;
  assign instr_valid = r_valid;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          ihit = 1'b0;
  logic [31:0]   iload = '0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   next_PC = '0;
  logic          halt = 1'b0;
  logic          imemREN;
  logic [31:0]   imemaddr;
  logic [31:0]   PC;
  logic [31:0]   PC4;
  logic [31:0]   instr;
  logic [31:0]   instr_pc4;
  logic          instr_valid;
  logic [CW-1:0] fetch_count;

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .COUNT_W  (CW)
  ) u_dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .iload       (iload),
    .stall       (stall),
    .redirect    (redirect),
    .next_PC     (next_PC),
    .halt        (halt),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .PC          (PC),
    .PC4         (PC4),
    .instr       (instr),
    .instr_pc4   (instr_pc4),
    .instr_valid (instr_valid),
    .fetch_count (fetch_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [31:0]   instr_pc4;
    logic          valid;
    logic [CW-1:0] count;
    logic          ren;
  } exp_t;

  exp_t q_exp[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, written from the behaviour description.
  logic [31:0]   m_pc, m_instr, m_ipc4, m_pend_pc;
  logic          m_valid, m_pend, m_halted;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = '0; m_ipc4 = '0; m_valid = 1'b0;
    m_cnt = '0; m_halted = 1'b0; m_pend = 1'b0; m_pend_pc = '0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    tgt = {next_PC[31:2], 2'b00};
    if (!m_halted) begin
      if (halt) begin
        m_halted = 1'b1; m_valid = 1'b0; m_pend = 1'b0;
      end else if (ihit && (redirect || m_pend)) begin
        m_pc = redirect ? tgt : m_pend_pc;
        m_valid = 1'b0; m_pend = 1'b0;
      end else if (ihit && !stall) begin
        m_instr = iload; m_ipc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end else begin
        if (redirect) begin m_pend = 1'b1; m_pend_pc = tgt; end
        if (!stall) m_valid = 1'b0;
      end
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, compare after the edge.
  task automatic step(input logic h, input logic s, input logic r, input logic [31:0] np,
                      input logic hl);
    exp_t e, g;
    ihit = h; stall = s; redirect = r; next_PC = np; halt = hl;
    iload = 32'hA500_0000 ^ PC;
    model_edge();
    e = '{pc: m_pc, instr: m_instr, instr_pc4: m_ipc4, valid: m_valid, count: m_cnt,
          ren: !m_halted};
    q_exp.push_back(e);
    @(posedge CLK);
    #1;
    g = q_exp.pop_front();
    check("pc", PC, g.pc);
    check("imemaddr", imemaddr, g.pc);
    check("pc4", PC4, g.pc + 32'd4);
    check("instr", instr, g.instr);
    check("instr_pc4", instr_pc4, g.instr_pc4);
    check("instr_valid", {31'd0, instr_valid}, {31'd0, g.valid});
    check("fetch_count", {28'd0, fetch_count}, {28'd0, g.count});
    check("imemREN", {31'd0, imemREN}, {31'd0, g.ren});
  endtask

  task automatic apply_reset();
    ihit = 0; stall = 0; redirect = 0; halt = 0; next_PC = '0;
    nRST = 1'b0;
    #2;
    model_reset();
    check("rst_pc", PC, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_count", {28'd0, fetch_count}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_ren", {31'd0, imemREN}, 32'd1);
  endtask

  initial begin
    model_reset();
    #1;
    apply_reset();

    // Back-to-back fetch, then a 3-cycle memory wait at PC=8.
    step(1, 0, 0, '0, 0);
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    check("first_instr", instr, 32'hA500_0000);
    step(1, 0, 0, '0, 0);
    check("pc_8", PC, 32'h8);
    repeat (3) step(0, 0, 0, '0, 0);
    check("wait_pc", PC, 32'h8);
    check("wait_bubble", {31'd0, instr_valid}, 32'd0);
    step(1, 0, 0, '0, 0);
    check("after_wait_pc", PC, 32'hC);
    check("after_wait_instr", instr, 32'hA500_0008);
    step(1, 0, 0, '0, 0);
    check("count_4", {28'd0, fetch_count}, 32'd4);

    // Stall with ihit at PC=0x10, then release.
    repeat (2) step(1, 1, 0, '0, 0);
    check("stall_pc", PC, 32'h10);
    check("stall_valid", {31'd0, instr_valid}, 32'd1);
    step(1, 0, 0, '0, 0);
    check("stall_rel_pc", PC, 32'h14);
    check("stall_rel_count", {28'd0, fetch_count}, 32'd5);

    // Same-cycle redirect squashes the arriving word.
    step(1, 0, 1, 32'h40, 0);
    check("redir_pc", PC, 32'h40);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_count", {28'd0, fetch_count}, 32'd5);
    step(1, 0, 0, '0, 0);

    // Redirect during a wait is held until ihit; low bits cleared.
    step(0, 0, 1, 32'h80, 0);
    step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    check("pend_pc", PC, 32'h80);
    check("pend_valid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 1, 32'h81, 0);
    step(0, 0, 0, '0, 0);
    step(1, 1, 0, '0, 0);
    check("pend_align", PC, 32'h80);

    // Newer pending redirect overwrites the older one.
    step(0, 0, 1, 32'h100, 0);
    step(0, 0, 1, 32'h200, 0);
    step(1, 0, 0, '0, 0);
    check("pend_newest", PC, 32'h200);

    // PC wrap and counter saturation.
    step(1, 0, 1, 32'hFFFF_FFF8, 0);
    step(1, 0, 0, '0, 0);
    check("pc4_wrap", PC4, 32'h0);
    step(1, 0, 0, '0, 0);
    check("pc_wrap", PC, 32'h0);
    check("ipc4_wrap", instr_pc4, 32'h0);
    repeat (10) step(1, 0, 0, '0, 0);
    check("count_sat", {28'd0, fetch_count}, 32'hF);

    // Halt beats redirect and accept; HALTED is sticky.
    step(1, 0, 1, 32'h300, 1);
    check("halt_ren", {31'd0, imemREN}, 32'd0);
    check("halt_pc", PC, 32'h28);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    repeat (2) step(1, 0, 1, 32'h400, 0);
    check("halt_sticky", PC, 32'h28);

    apply_reset();
    check("rehalt_pc", PC, 32'h0);
    step(1, 0, 0, '0, 0);

    if (q_exp.size() != 0) check("sb_empty", q_exp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch front end and program-counter owner for the pipelined MIPS datapath.
- Holds PC and drives the instruction-memory read request; exports PC/PC4 to the next-PC logic.
- Consumes its next_PC/redirect result and delivers fetched words to the IF/ID latch with a valid bit.
- Handles memory wait, hazard stall, late redirect (squash) and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- COUNT_W, 16, width of the delivered-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous reset, active low.
- ihit  in  1  instruction memory returns iload this cycle.
- iload  in  32  instruction word from memory.
- stall  in  1  hazard unit: IF/ID must hold.
- redirect  in  1  one-cycle pulse: branch taken / J / JR / JAL resolved, target on next_PC.
- next_PC  in  32  target from next-PC logic.
- halt  in  1  halt decoded/committed.
- imemREN  out  1  instruction read enable.
- imemaddr  out  32  instruction address (= PC).
- PC  out  32  current fetch PC.
- PC4  out  32  PC + 4, mod 2^32.
- instr  out  32  instruction to IF/ID.
- instr_pc4  out  32  PC4 of the delivered instruction.
- instr_valid  out  1  instr is a real instruction (0 = bubble).
- fetch_count  out  COUNT_W  delivered instructions, saturating.

Behaviour:
- Reset (async, nRST=0):
  - PC=RESET_PC; instr=0; instr_pc4=0; instr_valid=0; fetch_count=0.
  - State FETCH; pend=0; pend_pc=0.
  - imemREN=1 when nRST deasserts.
- States:
  - FETCH: imemREN=1, imemaddr=PC.
  - HALTED: imemREN=0, imemaddr=PC.
  - Outputs are combinational from state: PC4=PC+4, wraps 32'hFFFF_FFFC -> 0.
- Redirect capture:
  - redirect=1 without a same-cycle accept sets pend=1, pend_pc={next_PC[31:2],2'b00}.
  - A newer redirect overwrites an older pending one.
- Accept, in FETCH:
  - Squash accept = ihit & (redirect | pend); stall is ignored.
    - PC <= redirect ? {next_PC[31:2],2'b00} : pend_pc.
    - instr_valid <= 0; pend <= 0.
  - Normal accept = ihit & !stall & !redirect & !pend.
    - PC <= PC4; instr <= iload; instr_pc4 <= PC4; instr_valid <= 1.
    - fetch_count++, saturating at all-ones.
- Non-accept cycles:
  - stall=1: PC, instr, instr_pc4, instr_valid all hold.
  - stall=0 & !ihit: PC holds; instr_valid <= 0 (bubble); instr holds.
- Halt:
  - halt=1 in FETCH -> HALTED next edge; instr_valid <= 0; PC frozen; pend cleared.
  - halt has priority over any accept or redirect in the same cycle.
  - HALTED is exited only by reset.
- Reset mid-wait: any outstanding fetch is abandoned; memory ignores REN drop.
- Latency: a word delivered at edge N appears on instr/instr_valid after edge N. The next address is presented the same cycle.

Decomposition:
- Shared package: fetch_state_t enum {FETCH, HALTED}; word_t (32-bit); RESET_PC default constant.
- Single module; no sub-module. Redirect capture and PC register are under 30 lines each.

Test Plan:
- Reset, ihit=1 every cycle, iload=PC-tagged words -> PC 0,4,8,C; instr_valid=1 from the first edge; fetch_count=4 after 4 edges.
- Memory waits: ihit low 3 cycles at PC=8 -> PC holds 8, instr_valid=0 during wait; iload delivered once ihit rises; PC=C.
- stall=1 with ihit=1 at PC=10 -> PC, instr and instr_valid unchanged; release -> PC=14, word delivered once.
- Redirect to 0x40 with ihit=1 same cycle -> PC=40, instr_valid=0, fetch_count unchanged.
- Redirect to 0x80 during a 2-cycle ihit wait -> pend captured; on ihit PC=80, word squashed.
- Redirect to 0x81 with the same timing -> PC=80 (low bits cleared).
- halt and redirect in the same cycle -> HALTED; imemREN=0; PC unchanged; instr_valid=0.
- nRST pulse from HALTED -> PC=RESET_PC, imemREN=1.
